axi4_frame_reader: RTL and testbench
====================================

Name: axi4_frame_reader

Overview:
- AXI4 read master that moves one frame from the DDR frame buffer into a 64-bit pixel stream for the HDMI output path. This is the memory-mapped to stream direction.
- Issues fixed 64-beat INCR read bursts starting at FRAME_BASE_ADDR.
- Buffers returned beats in an internal synchronous FIFO and presents them on a valid/ready stream with start-of-frame and end-of-frame markers.
- Sits between the PS DDR port and the display-side async FIFO.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width (4 RGB565 pixels per beat).
- BURST_LEN, 64, beats per burst (ARLEN = BURST_LEN-1).
- BURSTS_PER_FRAME, 300, bursts per frame (320x240x2 B = 153600 B).
- FIFO_DEPTH, 128, internal FIFO entries; must be >= BURST_LEN and a power of 2.

Ports:
- clk_100Mhz  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  level; its rising edge requests one frame read.
- FRAME_BASE_ADDR  in  AXI_ADDR_WIDTH  frame buffer base; sampled when a frame is armed.
- ARADDR  out  AXI_ADDR_WIDTH  burst address.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address ready.
- ARLEN  out  8  constant BURST_LEN-1.
- ARSIZE  out  3  constant 3'b011.
- ARBURST  out  2  constant 2'b01 (INCR).
- ARCACHE  out  4  constant 4'b0011.
- ARPROT  out  3  constant 3'b000.
- RDATA  in  AXI_DATA_WIDTH  read data.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- RLAST  in  1  last beat of burst.
- RRESP  in  2  read response.
- m_tdata  out  AXI_DATA_WIDTH  stream data, FIFO head, first-word-fall-through.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tuser  out  1  first beat of frame.
- m_tlast  out  1  last beat of frame.
- reader_done  out  1  one-cycle pulse when the last burst of the frame completes.
- protocol_err  out  1  sticky RLAST-position mismatch flag.
- state  out  2  FSM state, for debug.
- ADDR_OFFSET  out  AXI_ADDR_WIDTH  current burst offset, for debug.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, FIFO emptied, counters 0. An in-flight AXI transaction is abandoned; the interconnect must be reset together with this block.
- FSM encoding: IDLE=0, ADDR_SEND=1, DATA_RECV=2, DONE=3.
- IDLE: a frame_start rising edge (edge detected with a 1-cycle delay register) does the following:
  - latches the base address;
  - clears ADDR_OFFSET and the burst count;
  - sets armed.
- IDLE -> ADDR_SEND when armed and free FIFO space >= BURST_LEN, i.e. occupancy <= FIFO_DEPTH-BURST_LEN. The free-space count includes reads popping in the same cycle.
- ADDR_SEND:
  - ARADDR = base + ADDR_OFFSET is registered on entry.
  - ARVALID is asserted the next cycle and held, with ARADDR stable, until ARVALID && ARREADY.
  - On that handshake: ARVALID <= 0, go to DATA_RECV.
- DATA_RECV:
  - RREADY = 1 for the whole state; space was reserved, so there is no backpressure.
  - Each RVALID && RREADY pushes RDATA and increments beat_cnt (0..BURST_LEN-1).
  - The burst ends on the handshake where beat_cnt == BURST_LEN-1.
  - If RLAST is not asserted on that beat, or is asserted on an earlier beat, set protocol_err. Length is governed by beat_cnt, not RLAST.
  - At burst end, if burst_cnt == BURSTS_PER_FRAME-1, go to DONE.
  - Otherwise ADDR_OFFSET += BURST_LEN*8 (512), burst_cnt++, return to IDLE with armed held; the next burst issues as soon as space allows.
- DONE: reader_done = 1 for exactly one cycle, armed cleared, ADDR_OFFSET cleared, go to IDLE.
- frame_start edges while armed or outside IDLE are ignored; there is no queueing.
- Stream side:
  - m_tvalid = FIFO not empty; pop on m_tvalid && m_tready.
  - An output beat counter (0..BURSTS_PER_FRAME*BURST_LEN-1 = 19199) drives m_tuser (count==0) and m_tlast (count==19199), then wraps to 0.
  - m_tdata, m_tuser and m_tlast are held stable while m_tvalid && !m_tready.
- Simultaneous FIFO push and pop: both occur and occupancy is unchanged.
- FIFO overflow cannot occur by construction; underflow is prevented by m_tvalid.
- RRESP is ignored unless the optional feature is enabled.

Optional Feature:
- Macro AXI_FRAME_READER_ERR_CNT_EN.
- When defined:
  - adds output port rresp_err_cnt (16 bits), which increments on every R handshake with RRESP != 2'b00 and saturates at 16'hFFFF;
  - the count clears on reset only.
- When undefined: the port and counter do not exist and RRESP is unused.

Test Plan:
- Reset, then one frame_start edge with base 0x1000_0000, ARREADY/RVALID always 1, m_tready = 1 -> 300 AR handshakes at 0x1000_0000, 0x1000_0200, ... 0x1002_5600; 19200 stream beats; m_tuser on beat 0; m_tlast on beat 19199; one reader_done pulse.
- m_tready held 0 -> exactly 2 bursts (128 beats) accepted, then ARVALID stays 0. Releasing m_tready resumes issue with the next address 0x...0400.
- ARREADY delayed 5 cycles -> ARVALID and ARADDR held stable for the whole wait; exactly one handshake.
- RLAST driven on beat 62 of burst 3 -> protocol_err = 1 and sticky; beat count still 64 per burst; frame completes.
- Second frame_start edge mid-frame -> ignored; exactly one reader_done. A new edge after DONE starts a frame with ADDR_OFFSET = 0.
- rst_n pulsed low mid-DATA_RECV -> all outputs 0 immediately; FIFO empty; the next frame_start reads from offset 0. With AXI_FRAME_READER_ERR_CNT_EN defined, RRESP = 2'b10 on 3 beats -> rresp_err_cnt = 3.

Source files
------------

// File: rtl/axi4_frame_reader_if.sv
// rtl/axi4_frame_reader_if.sv - AXI4 read channels plus output pixel stream bundle
interface axi4_frame_reader_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0] ARADDR;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic [3:0]                ARCACHE;
    logic [2:0]                ARPROT;
    logic [AXI_DATA_WIDTH-1:0] RDATA;
    logic                      RVALID;
    logic                      RREADY;
    logic                      RLAST;
    logic [1:0]                RRESP;
    logic [AXI_DATA_WIDTH-1:0] m_tdata;
    logic                      m_tvalid;
    logic                      m_tready;
    logic                      m_tuser;
    logic                      m_tlast;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        output m_tdata, m_tvalid, m_tuser, m_tlast,
        input  ARREADY, RDATA, RVALID, RLAST, RRESP, m_tready
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
        input  m_tdata, m_tvalid, m_tuser, m_tlast,
        output ARREADY, RDATA, RVALID, RLAST, RRESP, m_tready
    );
endinterface

// File: rtl/axi4_frame_reader.sv
// rtl/axi4_frame_reader.sv - DDR frame to pixel stream AXI4 read master (optional AXI_FRAME_READER_ERR_CNT_EN)
module axi4_frame_reader #(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int BURST_LEN        = 64,
    parameter int BURSTS_PER_FRAME = 300,
    parameter int FIFO_DEPTH       = 128
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
    axi4_frame_reader_if.master       bus,
    output logic                      reader_done,
    output logic                      protocol_err,
    output logic [1:0]                state,
    output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
`ifdef AXI_FRAME_READER_ERR_CNT_EN
    ,
    output logic [15:0]               rresp_err_cnt
`endif
);
    localparam int FRAME_BEATS = BURSTS_PER_FRAME * BURST_LEN;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int BEAT_W      = $clog2(BURST_LEN);
    localparam int BURST_W     = $clog2(BURSTS_PER_FRAME);
    localparam int OUT_W       = $clog2(FRAME_BEATS);

    localparam logic [CNT_W-1:0]          SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * (AXI_DATA_WIDTH / 8));
    localparam logic [BEAT_W-1:0]         BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]        BURST_LAST  = BURST_W'(BURSTS_PER_FRAME - 1);
    localparam logic [OUT_W-1:0]          OUT_LAST    = OUT_W'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_RECV = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      fs_q;
    logic                      armed_q;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic [AXI_ADDR_WIDTH-1:0] offset_q;
    logic [BURST_W-1:0]        burst_cnt_q;
    logic [BEAT_W-1:0]         beat_cnt_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                      arvalid_q;
    logic                      done_q;
    logic                      err_q;

    logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          count_d;
    logic [OUT_W-1:0]          out_cnt_q;

    logic fs_rise;
    logic push;
    logic pop;
    logic space_ok;

    assign fs_rise  = frame_start & ~fs_q;
    assign push     = (state_q == DATA_RECV) && bus.RVALID;
    assign pop      = (count_q != '0) && bus.m_tready;
    // Space check counts a pop in the same cycle, so a draining FIFO can issue one cycle earlier.
    assign space_ok = (count_q - CNT_W'(pop)) <= SPACE_LIMIT;

    // Frame/burst sequencing FSM with registered AR channel and status outputs.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fs_q        <= 1'b0;
            armed_q     <= 1'b0;
            base_q      <= '0;
            offset_q    <= '0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fs_q   <= frame_start;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        if (space_ok) begin
                            araddr_q <= base_q + offset_q;
                            state_q  <= ADDR_SEND;
                        end
                    end else if (fs_rise) begin
                        base_q      <= FRAME_BASE_ADDR;
                        offset_q    <= '0;
                        burst_cnt_q <= '0;
                        armed_q     <= 1'b1;
                    end
                end
                ADDR_SEND: begin
                    if (arvalid_q && bus.ARREADY) begin
                        arvalid_q  <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= DATA_RECV;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                DATA_RECV: begin
                    if (push) begin
                        if (beat_cnt_q == BEAT_LAST) begin
                            // Burst length comes from our own beat count; RLAST is only policed.
                            if (!bus.RLAST) err_q <= 1'b1;
                            beat_cnt_q <= '0;
                            if (burst_cnt_q == BURST_LAST) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                offset_q    <= offset_q + BURST_BYTES;
                                burst_cnt_q <= burst_cnt_q + 1'b1;
                                state_q     <= IDLE;
                            end
                        end else begin
                            if (bus.RLAST) err_q <= 1'b1;
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    armed_q     <= 1'b0;
                    offset_q    <= '0;
                    burst_cnt_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // FIFO pointers, occupancy and frame beat counter for the stream markers.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                out_cnt_q <= (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk_100Mhz) begin
        if (push) mem[wr_ptr_q] <= bus.RDATA;
    end

`ifdef AXI_FRAME_READER_ERR_CNT_EN
    logic [15:0] rresp_err_q;

    // Saturating count of R beats returning a non-OKAY response.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            rresp_err_q <= '0;
        end else if (push && (bus.RRESP != 2'b00) && (rresp_err_q != 16'hFFFF)) begin
            rresp_err_q <= rresp_err_q + 1'b1;
        end
    end

    assign rresp_err_cnt = rresp_err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^bus.RRESP;
`endif

    assign bus.ARADDR   = araddr_q;
    assign bus.ARVALID  = arvalid_q;
    assign bus.ARLEN    = 8'(BURST_LEN - 1);
    assign bus.ARSIZE   = 3'b011;
    assign bus.ARBURST  = 2'b01;
    assign bus.ARCACHE  = 4'b0011;
    assign bus.ARPROT   = 3'b000;
    assign bus.RREADY   = (state_q == DATA_RECV);
    assign bus.m_tvalid = (count_q != '0);
    assign bus.m_tdata  = bus.m_tvalid ? mem[rd_ptr_q] : '0;
    assign bus.m_tuser  = bus.m_tvalid && (out_cnt_q == '0);
    assign bus.m_tlast  = bus.m_tvalid && (out_cnt_q == OUT_LAST);
    assign reader_done  = done_q;
    assign protocol_err = err_q;
    assign state        = state_q;
    assign ADDR_OFFSET  = offset_q;
endmodule

// File: tb/tb_axi4_frame_reader.sv
// tb/tb_axi4_frame_reader.sv - directed scoreboard bench for axi4_frame_reader
module tb_axi4_frame_reader;
    localparam int BL          = 64;
    localparam int FRAME_BEATS = 19200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] base_addr;
    logic        reader_done;
    logic        protocol_err;
    logic [1:0]  state;
    logic [31:0] addr_offset;
`ifdef AXI_FRAME_READER_ERR_CNT_EN
    logic [15:0] rresp_err_cnt;
`endif

    axi4_frame_reader_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) bus ();

    axi4_frame_reader dut (
        .clk_100Mhz      (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .FRAME_BASE_ADDR (base_addr),
        .bus             (bus),
        .reader_done     (reader_done),
        .protocol_err    (protocol_err),
        .state           (state),
        .ADDR_OFFSET     (addr_offset)
`ifdef AXI_FRAME_READER_ERR_CNT_EN
        ,
        .rresp_err_cnt   (rresp_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [31:0] ar_q [$];
    logic [31:0] ar_log [$];
    int          beat, ar_wait, ar_wait_last, out_idx, beats_out, done_cnt, tuser_cnt, tlast_cnt;
    int          ar_delay;
    bit          tready_en;
    logic [31:0] bad_addr;
    logic [31:0] ar_hold;

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
        logic [31:0] x;
        x = a + 32'(b * 8);
        return {x, ~x ^ 32'h5A5A_0000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory and sink model: decides inputs for the coming edge and predicts handshakes.
    task automatic run_bus();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                ar_q.delete();
                beat = 0; ar_wait = 0; out_idx = 0;
                bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
            end else begin
                if (bus.ARVALID) begin
                    if (ar_wait > 0) chk("araddr_hold", 64'(bus.ARADDR), 64'(ar_hold));
                    ar_hold = bus.ARADDR;
                    bus.ARREADY = (ar_wait >= ar_delay);
                    if (bus.ARREADY) begin
                        ar_q.push_back(bus.ARADDR);
                        ar_log.push_back(bus.ARADDR);
                        ar_wait_last = ar_wait;
                        ar_wait = 0;
                    end else begin
                        ar_wait++;
                    end
                end else begin
                    bus.ARREADY = 1'b0;
                    ar_wait = 0;
                end
                if (ar_q.size() > 0) begin
                    bus.RVALID = 1'b1;
                    bus.RDATA  = beat_data(ar_q[0], beat);
                    bus.RLAST  = (ar_q[0] == bad_addr) ? (beat == BL - 2) : (beat == BL - 1);
                    bus.RRESP  = (ar_q[0] == bad_addr && beat >= 10 && beat < 13) ? 2'b10 : 2'b00;
                    if (bus.RREADY) begin
                        sb.push_back(bus.RDATA);
                        beat++;
                        if (beat == BL) begin
                            beat = 0;
                            void'(ar_q.pop_front());
                        end
                    end
                end else begin
                    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
                end
                bus.m_tready = tready_en;
                if (bus.m_tvalid && bus.m_tready) begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) chk("tdata", bus.m_tdata, sb.pop_front());
                    chk("tuser", 64'(bus.m_tuser), 64'(out_idx == 0));
                    chk("tlast", 64'(bus.m_tlast), 64'(out_idx == FRAME_BEATS - 1));
                    tuser_cnt += int'(bus.m_tuser);
                    tlast_cnt += int'(bus.m_tlast);
                    out_idx = (out_idx == FRAME_BEATS - 1) ? 0 : out_idx + 1;
                    beats_out++;
                end
                if (reader_done) done_cnt++;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        frame_start = 1'b1;
        repeat (2) @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; base_addr = '0;
        tready_en = 1'b1; ar_delay = 0; bad_addr = 32'hFFFF_FFF0;
        beat = 0; ar_wait = 0; ar_wait_last = 0; out_idx = 0;
        beats_out = 0; done_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; ar_hold = '0;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
        bus.RDATA = '0; bus.m_tready = 1'b0;
        fork
            run_bus();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 64'(bus.ARVALID), 64'(0));
        chk("rst_araddr", 64'(bus.ARADDR), 64'(0));
        chk("rst_rready", 64'(bus.RREADY), 64'(0));
        chk("rst_tvalid", 64'(bus.m_tvalid), 64'(0));
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_done", 64'(reader_done), 64'(0));
        rst_n = 1'b1;

        // Full frame, with a second edge mid-frame that must be ignored
        base_addr = 32'h1000_0000;
        pulse_start();
        for (int i = 0; i < 20000 && ar_log.size() < 150; i++) @(negedge clk);
        pulse_start();
        for (int i = 0; i < 30000 && !(done_cnt >= 1 && beats_out >= FRAME_BEATS); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < ar_log.size(); i++)
                if (ar_log[i] !== 32'h1000_0000 + 32'(i * 512)) bad++;
            chk("f1_ar_count", 64'(ar_log.size()), 64'(300));
            chk("f1_ar_addr_errs", 64'(bad), 64'(0));
        end
        chk("f1_last_addr", 64'(ar_log[ar_log.size() - 1]), 64'(32'h1002_5600));
        chk("f1_beats", 64'(beats_out), 64'(FRAME_BEATS));
        chk("f1_done", 64'(done_cnt), 64'(1));
        chk("f1_tuser_cnt", 64'(tuser_cnt), 64'(1));
        chk("f1_tlast_cnt", 64'(tlast_cnt), 64'(1));
        chk("f1_perr", 64'(protocol_err), 64'(0));
        chk("f1_state", 64'(state), 64'(0));
        chk("f1_offset", 64'(addr_offset), 64'(0));
        repeat (200) @(negedge clk);
        chk("f1_ignored_edge_ar", 64'(ar_log.size()), 64'(300));
        chk("f1_single_done", 64'(done_cnt), 64'(1));

        // New frame: delayed ARREADY, early RLAST and error responses on burst 3
        ar_log.delete(); done_cnt = 0; beats_out = 0; tuser_cnt = 0; tlast_cnt = 0;
        ar_delay = 5; base_addr = 32'h2000_0000; bad_addr = 32'h2000_0000 + 32'(3 * 512);
        pulse_start();
        for (int i = 0; i < 200 && ar_log.size() < 1; i++) @(negedge clk);
        chk("f2_first_addr", 64'(ar_log[0]), 64'(32'h2000_0000));
        chk("f2_ar_wait", 64'(ar_wait_last), 64'(5));
        chk("f2_ar_one_hs", 64'(ar_log.size()), 64'(1));
        ar_delay = 0;
        for (int i = 0; i < 1000 && ar_log.size() < 3; i++) @(negedge clk);
        chk("f2_perr_early", 64'(protocol_err), 64'(0));
        for (int i = 0; i < 1000 && ar_log.size() < 5; i++) @(negedge clk);
        chk("f2_perr_set", 64'(protocol_err), 64'(1));
        for (int i = 0; i < 30000 && !(done_cnt >= 1 && beats_out >= FRAME_BEATS); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("f2_ar_count", 64'(ar_log.size()), 64'(300));
        chk("f2_beats", 64'(beats_out), 64'(FRAME_BEATS));
        chk("f2_done", 64'(done_cnt), 64'(1));
        chk("f2_perr_sticky", 64'(protocol_err), 64'(1));
`ifdef AXI_FRAME_READER_ERR_CNT_EN
        chk("f2_rresp_cnt", 64'(rresp_err_cnt), 64'(3));
`endif

        // Sink stalled: only two bursts fit, then issue resumes at +0x400
        ar_log.delete(); beats_out = 0; tready_en = 1'b0; base_addr = 32'h3000_0000;
        pulse_start();
        repeat (400) @(negedge clk);
        chk("bp_ar_count", 64'(ar_log.size()), 64'(2));
        chk("bp_arvalid", 64'(bus.ARVALID), 64'(0));
        chk("bp_fifo_beats", 64'(sb.size()), 64'(128));
        chk("bp_tvalid", 64'(bus.m_tvalid), 64'(1));
        chk("bp_tuser_hold", 64'(bus.m_tuser), 64'(1));
        chk("bp_tdata_hold", bus.m_tdata, sb[0]);
        chk("bp_beats_out", 64'(beats_out), 64'(0));
        tready_en = 1'b1;
        for (int i = 0; i < 500 && ar_log.size() < 3; i++) @(negedge clk);
        chk("bp_third_addr", 64'(ar_log[2]), 64'(32'h3000_0400));

        // Reset pulse in the middle of a burst
        for (int i = 0; i < 1000 && !(ar_log.size() >= 4 && state == 2'd2); i++) @(negedge clk);
        chk("mid_state", 64'(state), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("mr_arvalid", 64'(bus.ARVALID), 64'(0));
        chk("mr_araddr", 64'(bus.ARADDR), 64'(0));
        chk("mr_rready", 64'(bus.RREADY), 64'(0));
        chk("mr_tvalid", 64'(bus.m_tvalid), 64'(0));
        chk("mr_tdata", bus.m_tdata, 64'(0));
        chk("mr_perr", 64'(protocol_err), 64'(0));
        chk("mr_state", 64'(state), 64'(0));
        chk("mr_offset", 64'(addr_offset), 64'(0));
`ifdef AXI_FRAME_READER_ERR_CNT_EN
        chk("mr_rresp_cnt", 64'(rresp_err_cnt), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ar_log.delete(); beats_out = 0; tuser_cnt = 0; base_addr = 32'h4000_0000;
        pulse_start();
        for (int i = 0; i < 200 && ar_log.size() < 1; i++) @(negedge clk);
        chk("rs_first_addr", 64'(ar_log[0]), 64'(32'h4000_0000));
        for (int i = 0; i < 500 && beats_out < 70; i++) @(negedge clk);
        chk("rs_beats", 64'(beats_out >= 70), 64'(1));
        chk("rs_tuser_cnt", 64'(tuser_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
